// File: rtl/flag_buf_arbiter.sv
// Round-robin N-to-1 arbiter feeding a single-word flag buffer (EMPTY/FULL FSM).
// Define FLAG_BUF_ARB_TIMEOUT_EN to discard a buffered word after T unserviced FULL cycles.
module flag_buf_arbiter #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int T = 16,
  localparam int S = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   ack,
  input  logic           clr_flag,
  output logic           flag,
  output logic [W-1:0]   dout,
  output logic [S-1:0]   src_id,
  output logic           drop
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [S-1:0]   ptr_reg, ptr_next;
  logic [W-1:0]   dout_reg, dout_next;
  logic [S-1:0]   src_reg, src_next;
  logic [N-1:0]   ack_reg, ack_next;
  logic           drop_reg, drop_next;
  logic [S-1:0]   cand_idx [N];
  logic [S-1:0]   win_idx;

`ifdef FLAG_BUF_ARB_TIMEOUT_EN
  logic [7:0]     cnt_reg, cnt_next;
`endif

  // cand_idx[k] is the requester examined k-th, starting at the pointer and wrapping at N.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [S:0] sum;
      assign sum           = {1'b0, ptr_reg} + (S+1)'(gi);
      assign cand_idx[gi]  = (sum >= (S+1)'(N)) ? S'(sum - (S+1)'(N)) : S'(sum);
    end
  endgenerate

  // Scan from the far end so the candidate closest to the pointer wins.
  always_comb begin
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) win_idx = cand_idx[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    dout_next  = dout_reg;
    src_next   = src_reg;
    ack_next   = '0;
    drop_next  = 1'b0;
`ifdef FLAG_BUF_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      EMPTY: begin
        if (|req) begin
          state_next        = FULL;
          dout_next         = din[int'(win_idx)*W +: W];
          src_next          = win_idx;
          ack_next[win_idx] = 1'b1;
          ptr_next          = (win_idx == S'(N - 1)) ? '0 : win_idx + S'(1);
`ifdef FLAG_BUF_ARB_TIMEOUT_EN
          cnt_next          = '0;
`endif
        end
      end
      FULL: begin
        // A consumer clear always beats the timeout on the same edge.
        if (clr_flag) begin
          state_next = EMPTY;
`ifdef FLAG_BUF_ARB_TIMEOUT_EN
        end else if (cnt_reg == 8'(T - 1)) begin
          state_next = EMPTY;
          drop_next  = 1'b1;
        end else begin
          cnt_next   = cnt_reg + 8'd1;
`endif
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      ptr_reg   <= '0;
      dout_reg  <= '0;
      src_reg   <= '0;
      ack_reg   <= '0;
      drop_reg  <= 1'b0;
`ifdef FLAG_BUF_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      dout_reg  <= dout_next;
      src_reg   <= src_next;
      ack_reg   <= ack_next;
      drop_reg  <= drop_next;
`ifdef FLAG_BUF_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  assign flag   = (state_reg == FULL);
  assign dout   = dout_reg;
  assign src_id = src_reg;
  assign ack    = ack_reg;
  assign drop   = drop_reg;

endmodule

// File: tb/tb_flag_buf_arbiter.sv
// Directed bench for flag_buf_arbiter (W=8, N=4, T=4); observed word is {flag, dout, src_id, ack, drop}.
module tb_flag_buf_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int T = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           clr_flag;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   ack;
  logic           flag;
  logic           drop;
  logic [W-1:0]   dout;
  logic [S-1:0]   src_id;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] got;
  logic [15:0] exp;

  always #5 clk = ~clk;

  flag_buf_arbiter #(.W(W), .N(N), .T(T)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .ack(ack),
    .clr_flag(clr_flag), .flag(flag), .dout(dout), .src_id(src_id), .drop(drop)
  );

  function automatic logic [15:0] pack(input logic f, input logic [7:0] d, input logic [1:0] s,
                                       input logic [3:0] a, input logic dr);
    return {f, d, s, a, dr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    got = {flag, dout, src_id, ack, drop};
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; clr_flag = 1'b0;
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step(); step();
    reset = 1'b0;
    exp = pack(1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   reset_state   %h", got); end
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    n_total++;
    if (got !== exp) $display("FAIL clr_in_empty got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   clr_in_empty  %h", got); end
  endtask

  task automatic test_grant();
    req = 4'b0101;
    step();
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0001, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL grant_a0 got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   grant_a0      %h", got); end
    step();
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL ack_one_cycle got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   ack_one_cycle %h", got); end
  endtask

  task automatic test_round_robin();
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    exp = pack(1'b0, 8'hA0, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL clear_holds got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   clear_holds   %h", got); end
    step();
    exp = pack(1'b1, 8'hA2, 2'd2, 4'b0100, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL rr_grant_a2 got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   rr_grant_a2   %h", got); end
    step();
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    exp = pack(1'b0, 8'hA2, 2'd2, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL rr_clear got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   rr_clear      %h", got); end
    step();
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0001, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL rr_wrap_a0 got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   rr_wrap_a0    %h", got); end
  endtask

  task automatic test_full_hold();
    req = 4'b1010;
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      din[1*W +: W] = 8'h10 + 8'(c);
      din[3*W +: W] = 8'h30 + 8'(c);
      step();
      n_total++;
      if (got !== exp) $display("FAIL full_hold[%0d] got=%h exp=%h", c, got, exp);
      else begin n_pass++; $display("ok   full_hold[%0d]  %h", c, got); end
    end
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    exp = pack(1'b0, 8'hA0, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL hold_clear got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   hold_clear    %h", got); end
    din[1*W +: W] = 8'h5B;
    step();
    exp = pack(1'b1, 8'h5B, 2'd1, 4'b0010, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL grant_new_din got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   grant_new_din %h", got); end
  endtask

  task automatic test_reset_mid_full();
    din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    clr_flag = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; clr_flag = 1'b0;
    exp = pack(1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL reset_mid_full got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   reset_mid_full %h", got); end
    req = 4'b1000;
    step();
    exp = pack(1'b1, 8'hA3, 2'd3, 4'b1000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL grant_after_reset got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   grant_after_reset %h", got); end
    req = 4'b0000; clr_flag = 1'b1;
    step();
    clr_flag = 1'b0; req = 4'b0110;
    step();
    exp = pack(1'b1, 8'hA1, 2'd1, 4'b0010, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL ptr_wrap got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   ptr_wrap      %h", got); end
    // Pointer now sits at 2; reset must bring requester 0 back to top priority.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    n_total++;
    if (got !== exp) $display("FAIL reset_priority got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   reset_priority %h", got); end
    req = 4'b0000;
  endtask

`ifdef FLAG_BUF_ARB_TIMEOUT_EN
  task automatic test_timeout();
    reset = 1'b1; req = '0; clr_flag = 1'b0;
    step();
    reset = 1'b0; req = 4'b0001;
    step();
    req = 4'b0000;
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0001, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL to_load got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   to_load       %h", got); end
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0000, 1'b0);
    for (int c = 1; c < T; c++) begin
      step();
      n_total++;
      if (got !== exp) $display("FAIL to_wait[%0d] got=%h exp=%h", c, got, exp);
      else begin n_pass++; $display("ok   to_wait[%0d]    %h", c, got); end
    end
    step();
    exp = pack(1'b0, 8'hA0, 2'd0, 4'b0000, 1'b1);
    n_total++;
    if (got !== exp) $display("FAIL to_drop got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   to_drop       %h", got); end
    step();
    exp = pack(1'b0, 8'hA0, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL to_drop_once got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   to_drop_once  %h", got); end
    req = 4'b0001;
    step();
    req = 4'b0000;
    for (int c = 1; c < T; c++) step();
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL to_before_clr got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   to_before_clr %h", got); end
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    exp = pack(1'b0, 8'hA0, 2'd0, 4'b0000, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL to_clr_wins got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   to_clr_wins   %h", got); end
  endtask
`else
  task automatic test_no_timeout();
    reset = 1'b1; req = '0; clr_flag = 1'b0;
    step();
    reset = 1'b0; req = 4'b0001;
    step();
    req = 4'b0000;
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0001, 1'b0);
    n_total++;
    if (got !== exp) $display("FAIL nt_load got=%h exp=%h", got, exp);
    else begin n_pass++; $display("ok   nt_load       %h", got); end
    exp = pack(1'b1, 8'hA0, 2'd0, 4'b0000, 1'b0);
    for (int c = 0; c < 300; c++) begin
      step();
      n_total++;
      if (got !== exp) $display("FAIL nt_hold[%0d] got=%h exp=%h", c, got, exp);
      else n_pass++;
    end
    $display("held FULL for 300 cycles");
  endtask
`endif

  initial begin
    test_reset();
    test_grant();
    test_round_robin();
    test_full_hold();
    test_reset_mid_full();
`ifdef FLAG_BUF_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/flag_buf_arbiter.md
FLAG_BUF_ARBITER -- requirements
Module: flag_buf_arbiter

Interface
REQ-001 Parameter W, default 8: data word width in bits.
REQ-002 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter T, default 16: timeout in cycles; legal range 2..255; used only when the timeout feature is compiled in.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N  bit i high = requester i holds a word to deliver.
REQ-007 din  input  N*W  requester i word at bits [i*W+W-1 : i*W].
REQ-008 ack  output  N  one-cycle pulse; bit i = requester i's word was taken.
REQ-009 clr_flag  input  1  consumer has read the buffered word.
REQ-010 flag  output  1  buffer holds a valid word.
REQ-011 dout  output  W  buffered word.
REQ-012 src_id  output  S  index of the requester that supplied dout; S = ceil(log2 N).
REQ-013 drop  output  1  one-cycle pulse: buffered word discarded by timeout.

Function
REQ-014 The block shall implement a two-state FSM, EMPTY (flag=0) and FULL (flag=1); all outputs shall be registered.
REQ-015 EMPTY with req=0: the block shall remain in EMPTY with no output change.
REQ-016 EMPTY with req!=0: at the next edge, the block shall:
- select the first requester with req high, scanning from the round-robin pointer upward modulo N;
- load dout with that requester's din slice and src_id with its index;
- set flag=1, set ack bit of the winner to 1, and move to FULL.
REQ-017 Grant latency shall be one cycle: ack and flag rise on the same edge; ack shall be high for exactly one cycle.
REQ-018 After a grant to index i, the pointer shall become (i+1) mod N.
REQ-019 FULL: req shall be ignored; dout and src_id shall hold; no ack shall be issued.
REQ-020 FULL with clr_flag=1: at the next edge the block shall clear flag and return to EMPTY; dout and src_id shall hold their last values.
REQ-021 A new load shall occur no earlier than one cycle after the return to EMPTY; there is no same-cycle clear-and-reload bypass.
REQ-022 clr_flag in EMPTY shall have no effect.
REQ-023 Requesters shall drop or update req in the cycle ack is seen; a req still high one cycle after ack is treated as a new word.
REQ-024 The block shall grant at most one word per FULL period and never overwrite a word while flag=1, except by the timeout of REQ-029.

Reset
REQ-025 reset=1 at a clock edge shall force EMPTY, flag=0, dout=0, src_id=0, ack=0, drop=0, pointer=0, and timeout counter=0.
REQ-026 reset shall take priority over every other input, including an in-progress grant or a pending clr_flag.
REQ-027 After reset, requester 0 shall have highest priority.

Configuration
REQ-028 Macro FLAG_BUF_ARB_TIMEOUT_EN shall enable the timeout feature.
REQ-029 With FLAG_BUF_ARB_TIMEOUT_EN defined:
- a counter shall clear on entry to FULL and increment each FULL cycle without clr_flag;
- on the edge where the count reaches T-1, the block shall clear flag, return to EMPTY, and pulse drop for one cycle.
REQ-030 With the timeout feature enabled, clr_flag in the same cycle as the timeout edge shall win: normal clear, drop stays 0.
REQ-031 Without FLAG_BUF_ARB_TIMEOUT_EN: drop shall be held at 0, no counter shall exist, T shall be ignored, and FULL persists until clr_flag.

Verification
REQ-032 Reset, then req=4'b0101 with din words A0/A1/A2/A3 -> one cycle later flag=1, dout=A0, src_id=0, ack=4'b0001 for one cycle.
REQ-033 From the REQ-032 state, clr_flag for one cycle with req=4'b0101 held -> the next load gives dout=A2, src_id=2, ack=4'b0100; the following round grants requester 0.
REQ-034 FULL with requesters 1 and 3 changing din each cycle -> dout and src_id remain constant and ack stays 0 until clr_flag.
REQ-035 clr_flag and reset asserted together mid-FULL -> all outputs zero, pointer=0, then req=4'b1000 gives src_id=3 after one cycle.
REQ-036 With FLAG_BUF_ARB_TIMEOUT_EN and T=4, hold FULL without clr_flag:
- required response: flag falls and drop pulses on the 4th edge after the load;
- repeat with clr_flag on that cycle: drop stays 0.
REQ-037 Without FLAG_BUF_ARB_TIMEOUT_EN, hold FULL for 300 cycles -> flag stays 1 and drop stays 0 throughout.
